// File: rtl/pzcorebus_csrbus_arbiter_pkg.sv
// CSR-profile pzcorebus field widths, command/response encodings and payload structs
// shared by the CSR arbiter, its round-robin selector and anything driving them.
package pzcorebus_csrbus_arbiter_pkg;

  localparam int ID_W   = 4;
  localparam int ADDR_W = 16;
  localparam int INFO_W = 2;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;
  localparam int MLEN_W = 8;

  typedef enum logic [2:0] {
    CMD_NULL             = 3'b000,
    CMD_WRITE            = 3'b001,
    CMD_WRITE_NON_POSTED = 3'b011,
    CMD_READ             = 3'b101
  } cmd_e;

  typedef enum logic [1:0] {
    RESP_NULL               = 2'b00,
    RESP_RESPONSE           = 2'b01,
    RESP_RESPONSE_WITH_DATA = 2'b11
  } resp_e;

  typedef struct packed {
    cmd_e              mcmd;
    logic [ID_W-1:0]   mid;
    logic [ADDR_W-1:0] maddr;
    logic [INFO_W-1:0] minfo;
    logic [DATA_W-1:0] mdata;
    logic [BE_W-1:0]   mdata_byteen;
  } cmd_t;

  typedef struct packed {
    resp_e             sresp;
    logic [ID_W-1:0]   sid;
    logic              serror;
    logic [INFO_W-1:0] sinfo;
    logic [DATA_W-1:0] sdata;
  } resp_t;

  // Commands that expect a response and therefore occupy the single outstanding slot.
  function automatic logic is_non_posted_command(cmd_e cmd);
    return (cmd == CMD_READ) || (cmd == CMD_WRITE_NON_POSTED);
  endfunction

endpackage

// File: rtl/pzcorebus_csrbus_rr_selector.sv
// Round-robin pick over a request vector; index i_ptr has top priority.
// Purely combinational (0 cycles); no backpressure of its own.
module pzcorebus_csrbus_rr_selector #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_index,
  output logic          o_valid
);

  logic [IW:0]   w_sum;
  logic [IW-1:0] w_idx;

  always_comb begin
    o_grant = '0;
    o_index = '0;
    o_valid = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      // i_ptr < N and k < N, so a single conditional subtract wraps the sum.
      w_sum = {1'b0, i_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(N)) w_sum = w_sum - (IW+1)'(N);
      w_idx = w_sum[IW-1:0];
      if (!o_valid && i_req[w_idx]) begin
        o_valid        = 1'b1;
        o_index        = w_idx;
        o_grant[w_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pzcorebus_csrbus_arbiter.sv
// Shares one CSR pzcorebus master port among SLAVES requesters; 0 added cycles (pass-through).
// Backpressure: only the granted requester sees scmd_accept; everyone stalls while a response is outstanding.
module pzcorebus_csrbus_arbiter
  import pzcorebus_csrbus_arbiter_pkg::*;
#(
  parameter int SLAVES = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [SLAVES-1:0]  i_slave_mcmd_valid,
  output logic [SLAVES-1:0]  o_slave_scmd_accept,
  input  cmd_t [SLAVES-1:0]  i_slave_cmd,
  output logic [SLAVES-1:0]  o_slave_sresp_valid,
  input  logic [SLAVES-1:0]  i_slave_mresp_accept,
  output resp_t [SLAVES-1:0] o_slave_resp,
  output logic [SLAVES-1:0]  o_slave_sresp_last,
  output logic               o_master_mcmd_valid,
  input  logic               i_master_scmd_accept,
  output cmd_t               o_master_cmd,
  output logic [MLEN_W-1:0]  o_master_mlength,
  output logic               o_master_mdata_valid,
  output logic               o_master_mdata_last,
  input  logic               i_master_sresp_valid,
  output logic               o_master_mresp_accept,
  input  resp_t              i_master_resp,
  output logic [SLAVES-1:0]  o_grant,
  output logic               o_busy
);

  localparam int INDEX_WIDTH = $clog2(SLAVES);

  typedef enum logic [1:0] {ARB, HOLD, WAIT} state_e;

  state_e                 r_state;
  logic [INDEX_WIDTH-1:0] r_ptr;
  logic [INDEX_WIDTH-1:0] r_owner;

  logic [SLAVES-1:0]      w_pick_grant;
  logic [INDEX_WIDTH-1:0] w_pick_index;
  logic                   w_pick_valid;
  logic [INDEX_WIDTH-1:0] w_sel_index;
  logic                   w_cmd_vld;
  logic                   w_cmd_ack;
  logic                   w_resp_path;
  logic                   w_resp_ack;

  function automatic logic [INDEX_WIDTH-1:0] next_index(logic [INDEX_WIDTH-1:0] idx);
    return (idx == INDEX_WIDTH'(SLAVES - 1)) ? '0 : idx + 1'b1;
  endfunction

  pzcorebus_csrbus_rr_selector #(
    .N  (SLAVES),
    .IW (INDEX_WIDTH)
  ) u_rr_selector (
    .i_req   (i_slave_mcmd_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_pick_grant),
    .o_index (w_pick_index),
    .o_valid (w_pick_valid)
  );

  assign w_sel_index = (r_state == ARB) ? w_pick_index : r_owner;

  // Outputs are qualified by i_rst_n so reset silences the port in the same cycle.
  always_comb begin
    w_cmd_vld = 1'b0;
    case (r_state)
      ARB:     w_cmd_vld = w_pick_valid;
      HOLD:    w_cmd_vld = i_slave_mcmd_valid[r_owner];
      default: w_cmd_vld = 1'b0;
    endcase
    w_cmd_vld = w_cmd_vld & i_rst_n;
  end

  assign w_cmd_ack   = w_cmd_vld & i_master_scmd_accept;
  assign w_resp_path = i_rst_n & (r_state == WAIT);
  assign w_resp_ack  = w_resp_path & i_master_sresp_valid & i_slave_mresp_accept[r_owner];

  always_comb begin
    o_slave_scmd_accept = '0;
    o_slave_sresp_valid = '0;
    o_grant             = '0;
    if (w_cmd_ack)   o_slave_scmd_accept[w_sel_index] = 1'b1;
    if (w_resp_path) o_slave_sresp_valid[r_owner]     = i_master_sresp_valid;
    if (i_rst_n) begin
      if (r_state == ARB) o_grant = w_pick_grant;
      else                o_grant[r_owner] = 1'b1;
    end
  end

  assign o_master_mcmd_valid   = w_cmd_vld;
  assign o_master_cmd          = i_slave_cmd[w_sel_index];
  assign o_master_mresp_accept = w_resp_path & i_slave_mresp_accept[r_owner];
  assign o_master_mlength      = '0;
  assign o_master_mdata_valid  = 1'b0;
  assign o_master_mdata_last   = 1'b0;
  assign o_slave_sresp_last    = '0;
  assign o_busy                = (r_state == WAIT);

  for (genvar g = 0; g < SLAVES; g++) begin : g_resp
    assign o_slave_resp[g] = i_master_resp;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ARB;
      r_ptr   <= '0;
      r_owner <= '0;
    end else begin
      case (r_state)
        ARB, HOLD: begin
          if (w_cmd_vld) begin
            // A presented command must stay put until accepted, so freeze the grant.
            r_owner <= w_sel_index;
            if (i_master_scmd_accept) begin
              r_ptr   <= next_index(w_sel_index);
              r_state <= is_non_posted_command(o_master_cmd.mcmd) ? WAIT : ARB;
            end else begin
              r_state <= HOLD;
            end
          end
        end
        WAIT:    if (w_resp_ack) r_state <= ARB;
        default: r_state <= ARB;
      endcase
    end
  end

  a_resp_only_when_outstanding: assert property (
    @(posedge i_clk) disable iff (!i_rst_n) i_master_sresp_valid |-> (r_state == WAIT)
  );

endmodule

// File: tb/tb_pzcorebus_csrbus_arbiter.sv
// Bench for pzcorebus_csrbus_arbiter with three requesters: vector table, directed
// corner sequences, then constrained-random traffic against a distance-based model.
module tb_pzcorebus_csrbus_arbiter;
  import pzcorebus_csrbus_arbiter_pkg::*;

  logic              clk;
  logic              rst_n;
  logic [2:0]        s_vld;
  logic [2:0]        s_acc;
  cmd_t [2:0]        s_cmd;
  logic [2:0]        s_rvld;
  logic [2:0]        s_racc;
  resp_t [2:0]       s_resp;
  logic [2:0]        s_rlast;
  logic              m_vld;
  logic              m_acc;
  cmd_t              m_cmd;
  logic [MLEN_W-1:0] m_len;
  logic              m_dvld;
  logic              m_dlast;
  logic              m_rvld;
  logic              m_racc;
  resp_t             m_resp;
  logic [2:0]        grant;
  logic              busy;

  int n_total = 0;
  int n_bad   = 0;

  pzcorebus_csrbus_arbiter #(.SLAVES(3)) dut (
    .i_clk                 (clk),
    .i_rst_n               (rst_n),
    .i_slave_mcmd_valid    (s_vld),
    .o_slave_scmd_accept   (s_acc),
    .i_slave_cmd           (s_cmd),
    .o_slave_sresp_valid   (s_rvld),
    .i_slave_mresp_accept  (s_racc),
    .o_slave_resp          (s_resp),
    .o_slave_sresp_last    (s_rlast),
    .o_master_mcmd_valid   (m_vld),
    .i_master_scmd_accept  (m_acc),
    .o_master_cmd          (m_cmd),
    .o_master_mlength      (m_len),
    .o_master_mdata_valid  (m_dvld),
    .o_master_mdata_last   (m_dlast),
    .i_master_sresp_valid  (m_rvld),
    .o_master_mresp_accept (m_racc),
    .i_master_resp         (m_resp),
    .o_grant               (grant),
    .o_busy                (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // {mcmd_valid, scmd_accept[2:0], grant[2:0], busy, sresp_valid[2:0], mresp_accept}
  function automatic logic [11:0] status();
    return {m_vld, s_acc, grant, busy, s_rvld, m_racc};
  endfunction

  function automatic cmd_t mkcmd(cmd_e t, logic [15:0] a, logic [31:0] d);
    cmd_t c;
    c.mcmd         = t;
    c.mid          = a[3:0];
    c.maddr        = a;
    c.minfo        = 2'b01;
    c.mdata        = d;
    c.mdata_byteen = 4'hF;
    return c;
  endfunction

  function automatic resp_t mkresp(logic err, logic [31:0] d);
    resp_t r;
    r.sresp  = RESP_RESPONSE_WITH_DATA;
    r.sid    = d[3:0];
    r.serror = err;
    r.sinfo  = 2'b10;
    r.sdata  = d;
    return r;
  endfunction

  task automatic nx();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    s_vld  = 3'b111;
    s_racc = 3'b111;
    m_acc  = 1'b1;
    m_rvld = 1'b0;
    #2;
    chk("reset_state", status(), 12'h000);
    chk("tied_fields", {m_len, m_dvld, m_dlast, s_rlast}, '0);
    s_vld  = '0;
    s_racc = '0;
    m_acc  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    nx();
  endtask

  typedef struct packed {
    logic [2:0] req;
    logic [2:0] np;
    logic       macc;
    logic       srv;
    logic [2:0] racc;
    logic [2:0] e_grant;
    logic [2:0] e_acc;
    logic       e_mvld;
    logic       e_busy;
    logic [2:0] e_srv;
    logic       e_mra;
  } vec_t;

  vec_t tbl [18];

  // Reference-model state: where the rotation starts, a frozen grant, an outstanding response.
  int         m_first;
  int         m_lock;
  bit         m_wait;
  int         m_owner;
  bit   [2:0] g_pend;
  cmd_t       g_cmd [3];
  bit         r_pend;
  resp_t      r_resp;

  function automatic int closest(logic [2:0] req, int first);
    int best = -1;
    int bd   = 99;
    for (int i = 0; i < 3; i++) begin
      if (req[i] && ((i - first + 3) % 3) < bd) begin
        bd   = (i - first + 3) % 3;
        best = i;
      end
    end
    return best;
  endfunction

  function automatic cmd_e rand_type();
    case ($urandom_range(0, 2))
      0:       return CMD_WRITE;
      1:       return CMD_WRITE_NON_POSTED;
      default: return CMD_READ;
    endcase
  endfunction

  task automatic run_random(input int cycles);
    int         sel;
    logic [2:0] eg, ea, esrv;
    logic       emv, ebusy, emra;
    m_first = 0; m_lock = -1; m_wait = 1'b0; m_owner = 0;
    g_pend  = '0; r_pend = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!g_pend[i] && $urandom_range(0, 2) == 0) begin
          g_pend[i] = 1'b1;
          g_cmd[i]  = mkcmd(rand_type(), 16'($urandom_range(0, 65535)), $urandom);
        end
        s_vld[i] = g_pend[i];
        s_cmd[i] = g_cmd[i];
      end
      m_acc = ($urandom_range(0, 3) != 0);
      if (m_wait && !r_pend && $urandom_range(0, 1) == 1) begin
        r_pend = 1'b1;
        r_resp = mkresp(1'($urandom_range(0, 1)), $urandom);
      end
      m_rvld = r_pend;
      m_resp = r_resp;
      s_racc = 3'($urandom_range(0, 7));
      @(negedge clk);
      sel = -1;
      if (m_wait) begin
        emv = 1'b0; ea = '0; ebusy = 1'b1;
        eg   = 3'(1 << m_owner);
        esrv = m_rvld ? eg : 3'b000;
        emra = s_racc[m_owner];
      end else begin
        sel   = (m_lock >= 0) ? m_lock : closest(s_vld, m_first);
        emv   = (sel >= 0) && s_vld[sel];
        eg    = (sel >= 0) ? 3'(1 << sel) : 3'b000;
        ea    = (emv && m_acc) ? eg : 3'b000;
        ebusy = 1'b0; esrv = '0; emra = 1'b0;
      end
      chk($sformatf("rnd%0d_ctl", c), status(), {emv, ea, eg, ebusy, esrv, emra});
      if (emv)   chk($sformatf("rnd%0d_cmd", c), m_cmd, g_cmd[sel]);
      if (|esrv) chk($sformatf("rnd%0d_resp", c), s_resp[m_owner], r_resp);
      if (m_wait) begin
        if (m_rvld && s_racc[m_owner]) begin
          m_wait = 1'b0;
          r_pend = 1'b0;
        end
      end else if (emv) begin
        if (m_acc) begin
          g_pend[sel] = 1'b0;
          m_first     = (sel + 1) % 3;
          m_lock      = -1;
          if (g_cmd[sel].mcmd != CMD_WRITE) begin
            m_wait  = 1'b1;
            m_owner = sel;
          end
        end else begin
          m_lock = sel;
        end
      end
      nx();
    end
    s_vld  = '0;
    m_rvld = 1'b0;
  endtask

  initial begin
    int gi;
    // req   np    macc srv racc   grant  acc    mvld busy srv    mra
    tbl[0]  = '{3'b111, 3'b000, 1'b1, 1'b0, 3'b000, 3'b001, 3'b001, 1'b1, 1'b0, 3'b000, 1'b0};
    tbl[1]  = '{3'b111, 3'b000, 1'b1, 1'b0, 3'b000, 3'b010, 3'b010, 1'b1, 1'b0, 3'b000, 1'b0};
    tbl[2]  = '{3'b111, 3'b000, 1'b1, 1'b0, 3'b000, 3'b100, 3'b100, 1'b1, 1'b0, 3'b000, 1'b0};
    tbl[3]  = '{3'b111, 3'b000, 1'b1, 1'b0, 3'b000, 3'b001, 3'b001, 1'b1, 1'b0, 3'b000, 1'b0};
    tbl[4]  = '{3'b111, 3'b000, 1'b1, 1'b0, 3'b000, 3'b010, 3'b010, 1'b1, 1'b0, 3'b000, 1'b0};
    tbl[5]  = '{3'b111, 3'b000, 1'b1, 1'b0, 3'b000, 3'b100, 3'b100, 1'b1, 1'b0, 3'b000, 1'b0};
    tbl[6]  = '{3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0};
    tbl[7]  = '{3'b110, 3'b000, 1'b1, 1'b0, 3'b000, 3'b010, 3'b010, 1'b1, 1'b0, 3'b000, 1'b0};
    tbl[8]  = '{3'b011, 3'b000, 1'b1, 1'b0, 3'b000, 3'b001, 3'b001, 1'b1, 1'b0, 3'b000, 1'b0};
    tbl[9]  = '{3'b100, 3'b000, 1'b0, 1'b0, 3'b000, 3'b100, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0};
    tbl[10] = '{3'b111, 3'b000, 1'b0, 1'b0, 3'b000, 3'b100, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0};
    tbl[11] = '{3'b111, 3'b000, 1'b1, 1'b0, 3'b000, 3'b100, 3'b100, 1'b1, 1'b0, 3'b000, 1'b0};
    tbl[12] = '{3'b010, 3'b010, 1'b1, 1'b0, 3'b000, 3'b010, 3'b010, 1'b1, 1'b0, 3'b000, 1'b0};
    tbl[13] = '{3'b101, 3'b000, 1'b1, 1'b0, 3'b000, 3'b010, 3'b000, 1'b0, 1'b1, 3'b000, 1'b0};
    tbl[14] = '{3'b101, 3'b000, 1'b1, 1'b1, 3'b101, 3'b010, 3'b000, 1'b0, 1'b1, 3'b010, 1'b0};
    tbl[15] = '{3'b101, 3'b000, 1'b1, 1'b1, 3'b010, 3'b010, 3'b000, 1'b0, 1'b1, 3'b010, 1'b1};
    tbl[16] = '{3'b101, 3'b000, 1'b1, 1'b0, 3'b000, 3'b100, 3'b100, 1'b1, 1'b0, 3'b000, 1'b0};
    tbl[17] = '{3'b001, 3'b000, 1'b1, 1'b0, 3'b000, 3'b001, 3'b001, 1'b1, 1'b0, 3'b000, 1'b0};

    rst_n = 1'b0; s_vld = '0; s_racc = '0; m_acc = 1'b0; m_rvld = 1'b0;
    s_cmd = '0; m_resp = '0;
    nx();
    do_reset();

    for (int k = 0; k < 18; k++) begin
      for (int i = 0; i < 3; i++)
        s_cmd[i] = mkcmd(tbl[k].np[i] ? CMD_READ : CMD_WRITE, 16'h0100 + 16'(i), 32'hD000 + 32'(i));
      s_vld  = tbl[k].req;
      m_acc  = tbl[k].macc;
      m_rvld = tbl[k].srv;
      s_racc = tbl[k].racc;
      m_resp = mkresp(1'b0, 32'hBEEF00 + 32'(k));
      @(negedge clk);
      chk($sformatf("vec%0d", k), status(), {tbl[k].e_mvld, tbl[k].e_acc, tbl[k].e_grant,
          tbl[k].e_busy, tbl[k].e_srv, tbl[k].e_mra});
      gi = -1;
      for (int i = 0; i < 3; i++) if (tbl[k].e_grant[i]) gi = i;
      if (tbl[k].e_mvld && gi >= 0) chk($sformatf("vec%0d_cmd", k), m_cmd, s_cmd[gi]);
      if (|tbl[k].e_srv && gi >= 0) chk($sformatf("vec%0d_resp", k), s_resp[gi], m_resp);
      nx();
    end
    s_vld = '0; m_rvld = 1'b0; s_racc = '0;

    // Simple read round trip.
    do_reset();
    s_cmd[0] = mkcmd(CMD_READ, 16'h0010, 32'h0);
    s_vld = 3'b001; m_acc = 1'b1;
    @(negedge clk);
    chk("t1_issue", status(), {1'b1, 3'b001, 3'b001, 1'b0, 3'b000, 1'b0});
    chk("t1_addr", m_cmd.maddr, 16'h0010);
    nx();
    s_vld = '0; m_rvld = 1'b1; m_resp = mkresp(1'b0, 32'hA5); s_racc = 3'b011;
    @(negedge clk);
    chk("t1_resp", status(), {1'b0, 3'b000, 3'b001, 1'b1, 3'b001, 1'b1});
    chk("t1_data", s_resp[0].sdata, 32'hA5);
    nx();
    m_rvld = 1'b0; s_racc = '0;
    @(negedge clk);
    chk("t1_idle", status(), 12'h000);
    nx();

    // Grant frozen on a stalled command while another requester arrives.
    s_cmd[1] = mkcmd(CMD_READ, 16'h0200, 32'h0);
    s_cmd[0] = mkcmd(CMD_WRITE, 16'h0300, 32'h1234);
    m_acc = 1'b0;
    for (int c = 0; c < 5; c++) begin
      s_vld = (c >= 2) ? 3'b011 : 3'b010;
      @(negedge clk);
      chk($sformatf("t3_hold%0d", c), status(), {1'b1, 3'b000, 3'b010, 1'b0, 3'b000, 1'b0});
      chk($sformatf("t3_cmd%0d", c), m_cmd, s_cmd[1]);
      nx();
    end
    m_acc = 1'b1; s_vld = 3'b011;
    @(negedge clk);
    chk("t3_acc", status(), {1'b1, 3'b010, 3'b010, 1'b0, 3'b000, 1'b0});
    nx();
    s_vld = 3'b001; m_rvld = 1'b1; m_resp = mkresp(1'b0, 32'h77); s_racc = 3'b010;
    @(negedge clk);
    chk("t3_resp", status(), {1'b0, 3'b000, 3'b010, 1'b1, 3'b010, 1'b1});
    nx();
    m_rvld = 1'b0; s_racc = '0;
    @(negedge clk);
    chk("t3_next", status(), {1'b1, 3'b001, 3'b001, 1'b0, 3'b000, 1'b0});
    nx();

    // Non-posted write blocks a pending read until one cycle after the ack.
    s_cmd[0] = mkcmd(CMD_WRITE_NON_POSTED, 16'h0400, 32'hCAFE);
    s_cmd[1] = mkcmd(CMD_READ, 16'h0500, 32'h0);
    s_vld = 3'b001;
    @(negedge clk);
    chk("t4_np", status(), {1'b1, 3'b001, 3'b001, 1'b0, 3'b000, 1'b0});
    nx();
    s_vld = 3'b010;
    @(negedge clk);
    chk("t4_block", status(), {1'b0, 3'b000, 3'b001, 1'b1, 3'b000, 1'b0});
    nx();
    m_rvld = 1'b1; m_resp = mkresp(1'b1, 32'h0); s_racc = 3'b001;
    @(negedge clk);
    chk("t4_ack", status(), {1'b0, 3'b000, 3'b001, 1'b1, 3'b001, 1'b1});
    chk("t4_err", s_resp[0].serror, 1'b1);
    nx();
    m_rvld = 1'b0; s_racc = '0;
    @(negedge clk);
    chk("t4_issue", status(), {1'b1, 3'b010, 3'b010, 1'b0, 3'b000, 1'b0});
    nx();

    // Response held while the owner refuses it.
    s_vld = '0; m_rvld = 1'b1; m_resp = mkresp(1'b0, 32'h55); s_racc = 3'b101;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("t5_hold%0d", c), status(), {1'b0, 3'b000, 3'b010, 1'b1, 3'b010, 1'b0});
      nx();
    end
    s_racc = 3'b010;
    @(negedge clk);
    chk("t5_ack", status(), {1'b0, 3'b000, 3'b010, 1'b1, 3'b010, 1'b1});
    nx();
    m_rvld = 1'b0; s_racc = '0;
    @(negedge clk);
    chk("t5_arb", status(), 12'h000);
    nx();

    // Asynchronous reset while a response is outstanding.
    s_cmd[0] = mkcmd(CMD_READ, 16'h0600, 32'h0);
    s_vld = 3'b001; m_acc = 1'b1;
    @(negedge clk);
    chk("t6_issue", status(), {1'b1, 3'b001, 3'b001, 1'b0, 3'b000, 1'b0});
    nx();
    s_cmd[2] = mkcmd(CMD_READ, 16'h0700, 32'h0);
    s_vld = 3'b100; m_rvld = 1'b1; s_racc = 3'b000;
    @(negedge clk);
    chk("t6_wait", status(), {1'b0, 3'b000, 3'b001, 1'b1, 3'b001, 1'b0});
    #2 rst_n = 1'b0;
    #1 chk("t6_rst", status(), 12'h000);
    m_rvld = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("t6_rel", status(), {1'b1, 3'b100, 3'b100, 1'b0, 3'b000, 1'b0});
    chk("t6_addr", m_cmd.maddr, 16'h0700);
    nx();
    s_vld = '0; m_rvld = 1'b1; m_resp = mkresp(1'b0, 32'h5A); s_racc = 3'b100;
    @(negedge clk);
    chk("t6_resp", status(), {1'b0, 3'b000, 3'b100, 1'b1, 3'b100, 1'b1});
    chk("t6_data", s_resp[2].sdata, 32'h5A);
    nx();
    m_rvld = 1'b0; s_racc = '0;
    @(negedge clk);
    chk("t6_done", status(), 12'h000);
    nx();

    do_reset();
    run_random(600);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
